// File: rtl/pwm_pkg.sv
// Register map, CONFIG/STATUS bit positions and shared types for the PWM bank.
package pwm_pkg;

    localparam int unsigned PWM_PERIOD        = 0;
    localparam int unsigned PWM_ON_TIME       = 1;
    localparam int unsigned PWM_CONFIG        = 2;
    localparam int unsigned PWM_STATUS        = 3;
    localparam int unsigned NOS_PWM_REGISTERS = 4;

    localparam int unsigned CFG_EN      = 0;
    localparam int unsigned CFG_MODE    = 1;
    localparam int unsigned CFG_INV     = 2;
    localparam int unsigned CFG_SYNC_EN = 3;
    localparam int unsigned CFG_W       = 4;

    localparam int unsigned ST_PWM  = 31;
    localparam int unsigned ST_UPD  = 30;
    localparam int unsigned ST_DONE = 29;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTRE = 1'b1
    } pwm_mode_t;

endpackage

// File: rtl/pwm_bank_if.sv
// Register bus between the decode fabric and the PWM bank.
interface pwm_bank_if;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  reg_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (output wr_en, rd_en, reg_addr, wr_data, input rd_data, rd_valid);
    modport slave  (input wr_en, rd_en, reg_addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/pwm_core.sv
// One PWM channel: counter, direction, compare, double-buffered timing and status.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_period,
    input  logic             wr_on,
    input  logic             wr_cfg,
    input  logic             rd_status,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             sync_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] on_o,
    output logic [CFG_W-1:0] cfg_o,
    output logic [31:0]      status_c,
    output logic             pwm_o
);

    logic [CNT_W-1:0] per_pend_q, per_pend_d, on_pend_q, on_pend_d;
    logic [CNT_W-1:0] per_act_q, per_act_d, on_act_q, on_act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, last_c;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             dir_q, dir_d, upd_q, upd_d, done_q, done_d, pwm_q, pwm_d;
    logic             en_c, sync_hit_c, boundary_c, raw_c;
    pwm_mode_t        mode_c;

    // State registers; pwm_o drops asynchronously with reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            per_pend_q <= '0;
            on_pend_q  <= '0;
            per_act_q  <= '0;
            on_act_q   <= '0;
            cnt_q      <= '0;
            cfg_q      <= '0;
            dir_q      <= 1'b0;
            upd_q      <= 1'b0;
            done_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            per_pend_q <= per_pend_d;
            on_pend_q  <= on_pend_d;
            per_act_q  <= per_act_d;
            on_act_q   <= on_act_d;
            cnt_q      <= cnt_d;
            cfg_q      <= cfg_d;
            dir_q      <= dir_d;
            upd_q      <= upd_d;
            done_q     <= done_d;
            pwm_q      <= pwm_d;
        end
    end

    // Counter sequencing, period boundary detect and pending->active transfer.
    always_comb begin
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        per_act_d  = per_act_q;
        on_act_d   = on_act_q;
        boundary_c = 1'b0;
        en_c       = cfg_q[CFG_EN];
        mode_c     = pwm_mode_t'(cfg_q[CFG_MODE]);
        sync_hit_c = en_c & cfg_q[CFG_SYNC_EN] & sync_in;
        last_c     = per_act_q - CNT_W'(1);

        if (!en_c) begin
            cnt_d     = '0;
            dir_d     = 1'b0;
            per_act_d = per_pend_q;
            on_act_d  = on_pend_q;
        end else if (sync_hit_c) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (per_act_q == '0) begin
            // A zero period idles at 0 but still lets new timing load every cycle.
            cnt_d      = '0;
            dir_d      = 1'b0;
            boundary_c = 1'b1;
        end else if (mode_c == PWM_EDGE) begin
            dir_d = 1'b0;
            if (cnt_q >= last_c) begin
                cnt_d      = '0;
                boundary_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!dir_q) begin
            // Top value is held for two cycles: once going up, once going down.
            if (cnt_q >= last_c) dir_d = 1'b1;
            else                 cnt_d = cnt_q + CNT_W'(1);
        end else if (cnt_q == '0) begin
            dir_d      = 1'b0;
            boundary_c = 1'b1;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (boundary_c) begin
            per_act_d = per_pend_q;
            on_act_d  = on_pend_q;
        end
    end

    // Bus-side registers, sticky status flags and registered output.
    always_comb begin
        per_pend_d = per_pend_q;
        on_pend_d  = on_pend_q;
        cfg_d      = cfg_q;
        upd_d      = upd_q;
        done_d     = done_q;
        raw_c      = 1'b0;

        if (wr_period) per_pend_d = wr_data;
        if (wr_on)     on_pend_d  = wr_data;
        if (wr_cfg)    cfg_d      = wr_data[CFG_W-1:0];

        if (wr_period || wr_on)             upd_d = 1'b1;
        else if (boundary_c || !en_c)       upd_d = 1'b0;

        if (boundary_c)     done_d = 1'b1;
        else if (rd_status) done_d = 1'b0;

        if (en_c && (per_act_q != '0) && (cnt_q < on_act_q)) raw_c = 1'b1;
        pwm_d = raw_c ^ cfg_q[CFG_INV];
    end

    // Status word assembly.
    always_comb begin
        status_c              = '0;
        status_c[ST_PWM]      = pwm_q;
        status_c[ST_UPD]      = upd_q;
        status_c[ST_DONE]     = done_q;
        status_c[CFG_W-1:0]   = cfg_q;
    end

    assign period_o = per_pend_q;
    assign on_o     = on_pend_q;
    assign cfg_o    = cfg_q;
    assign pwm_o    = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: address decode, per-channel cores and registered read port.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CNT_W     = 16,
    parameter logic [7:0]  BASE_ADDR = 8'd16
) (
    input  logic            clk,
    input  logic            reset,
    pwm_bank_if.slave       bus,
    input  logic            sync_in,
    output logic [N_CH-1:0] pwm_out
);

    localparam int unsigned WIN = NOS_PWM_REGISTERS * N_CH;

    logic [8:0]  off_c;
    logic [6:0]  ch_c;
    logic [1:0]  k_c;
    logic        in_win_c;
    logic [31:0] rd_or [N_CH+1];
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        unused_wr_hi;

    // Window decode: channel index and register offset within the channel.
    always_comb begin
        off_c    = {1'b0, bus.reg_addr} - {1'b0, BASE_ADDR};
        in_win_c = (bus.reg_addr >= BASE_ADDR) && (off_c < 9'(WIN));
        ch_c     = off_c[8:2];
        k_c      = off_c[1:0];
    end

    assign rd_or[0] = '0;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic             sel_c;
        logic [CNT_W-1:0] per_w, on_w;
        logic [CFG_W-1:0] cfg_w;
        logic [31:0]      status_w, word_c;

        assign sel_c = in_win_c && (ch_c == 7'(c));

        pwm_core #(.CNT_W(CNT_W)) u_core (
            .clk       (clk),
            .reset     (reset),
            .wr_period (bus.wr_en && sel_c && (k_c == 2'(PWM_PERIOD))),
            .wr_on     (bus.wr_en && sel_c && (k_c == 2'(PWM_ON_TIME))),
            .wr_cfg    (bus.wr_en && sel_c && (k_c == 2'(PWM_CONFIG))),
            .rd_status (bus.rd_en && sel_c && (k_c == 2'(PWM_STATUS))),
            .wr_data   (bus.wr_data[CNT_W-1:0]),
            .sync_in   (sync_in),
            .period_o  (per_w),
            .on_o      (on_w),
            .cfg_o     (cfg_w),
            .status_c  (status_w),
            .pwm_o     (pwm_out[c])
        );

        // Per-channel read word, zero unless this channel is addressed.
        always_comb begin
            word_c = '0;
            if (sel_c) begin
                case (k_c)
                    2'(PWM_PERIOD):  word_c = 32'(per_w);
                    2'(PWM_ON_TIME): word_c = 32'(on_w);
                    2'(PWM_CONFIG):  word_c = 32'(cfg_w);
                    default:         word_c = status_w;
                endcase
            end
        end

        assign rd_or[c+1] = rd_or[c] | word_c;
    end

    // Read data is captured on a valid read and held until the next one.
    always_comb begin
        rd_valid_d = bus.rd_en && in_win_c;
        rd_data_d  = rd_valid_d ? rd_or[N_CH] : rd_data_q;
    end

    // Read port registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign unused_wr_hi = ^bus.wr_data;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: register table, waveform windows, status scoreboard.
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       sync_in;
    logic [3:0] pwm_out;

    pwm_bank_if bus ();

    pwm_bank #(.N_CH(4), .CNT_W(16), .BASE_ADDR(8'd16)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .sync_in (sync_in),
        .pwm_out (pwm_out)
    );

    always #10 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          vld;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.reg_addr = a; bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, input logic [31:0] e, input string nm, input bit vld);
        @(negedge clk);
        bus.rd_en = 1'b1; bus.reg_addr = a;
        if (vld) begin exp_q.push_back(e); name_q.push_back(nm); end
        @(negedge clk);
        bus.rd_en = 1'b0;
        if (!vld) check({nm, "_no_valid"}, 64'(bus.rd_valid), 64'd0);
    endtask

    task automatic sample(input int ch, input int n, output logic [63:0] v);
        v = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            v = {v[62:0], 1'(pwm_out >> ch)};
        end
    endtask

    // Scoreboard: every rd_valid pops the oldest expected read word.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rd_valid got=%h want=none", bus.rd_data);
            end else begin
                check(name_q.pop_front(), 64'(bus.rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v, e, v0, v1, v2, e01, e2;
        int          wait_cyc;

        reset = 1'b0; sync_in = 1'b0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.reg_addr = '0; bus.wr_data = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", 64'(pwm_out), 64'd0);
        check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        tbl[0]  = '{1'b1, 8'd16, 32'd10,         1'b0};
        tbl[1]  = '{1'b1, 8'd17, 32'd3,          1'b0};
        tbl[2]  = '{1'b1, 8'd24, 32'h0001_2345,  1'b0};
        tbl[3]  = '{1'b1, 8'd30, 32'hFFFF_FFF4,  1'b0};
        tbl[4]  = '{1'b1, 8'd22, 32'hFFFF_FFF0,  1'b0};
        tbl[5]  = '{1'b1, 8'd12, 32'd99,         1'b0};
        tbl[6]  = '{1'b1, 8'd32, 32'h77,         1'b0};
        tbl[7]  = '{1'b0, 8'd16, 32'd10,         1'b1};
        tbl[8]  = '{1'b0, 8'd17, 32'd3,          1'b1};
        tbl[9]  = '{1'b0, 8'd24, 32'h0000_2345,  1'b1};
        tbl[10] = '{1'b0, 8'd30, 32'h0000_0004,  1'b1};
        tbl[11] = '{1'b0, 8'd31, 32'h8000_0004,  1'b1};
        tbl[12] = '{1'b0, 8'd22, 32'h0000_0000,  1'b1};
        tbl[13] = '{1'b0, 8'd15, 32'h0,          1'b0};
        tbl[14] = '{1'b0, 8'd32, 32'h0,          1'b0};

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
            else           bus_rd(tbl[i].addr, tbl[i].data, $sformatf("vec%0d", i), tbl[i].vld);
        end
        check("invert_disabled_pwm3", 64'(pwm_out[3]), 64'd1);

        // Edge mode: ch0 P=10 ON=3
        bus_wr(8'd18, 32'd1);
        sample(0, 30, v);
        e = '0;
        for (int k = 1; k <= 30; k++) e = {e[62:0], (((k - 1) % 10) < 3)};
        check("edge_ch0", v, e);

        // Centre mode: ch1 P=8 ON=2
        bus_wr(8'd20, 32'd8);
        bus_wr(8'd21, 32'd2);
        bus_wr(8'd22, 32'd3);
        sample(1, 40, v);
        e = '0;
        for (int k = 1; k <= 40; k++) begin
            int j;
            j = (k - 1) % 16;
            e = {e[62:0], (j < 2) || (j > 13)};
        end
        check("centre_ch1", v, e);

        // Double buffering: ON 3 -> 7 mid-period, with status reads around the boundary
        bus_wr(8'd18, 32'd0);
        bus_wr(8'd18, 32'd1);
        v = '0; e = '0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            v = {v[62:0], pwm_out[0]};
            e = {e[62:0], (k <= 10) ? (((k - 1) % 10) < 3) : (((k - 11) % 10) < 7)};
            case (k)
                5:  begin bus.wr_en = 1'b1; bus.reg_addr = 8'd17; bus.wr_data = 32'd7; end
                6:  bus.wr_en = 1'b0;
                7:  begin bus.rd_en = 1'b1; bus.reg_addr = 8'd19;
                          exp_q.push_back(32'h6000_0001); name_q.push_back("status_pending"); end
                8:  bus.rd_en = 1'b0;
                14: begin bus.rd_en = 1'b1; bus.reg_addr = 8'd19;
                          exp_q.push_back(32'hA000_0001); name_q.push_back("status_done_set"); end
                15: bus.rd_en = 1'b0;
                16: begin bus.rd_en = 1'b1; bus.reg_addr = 8'd19;
                          exp_q.push_back(32'h8000_0001); name_q.push_back("status_done_clr"); end
                17: bus.rd_en = 1'b0;
                default: ;
            endcase
        end
        check("double_buffer_ch0", v, e);

        // Corner values on ch2: P=0 gives constant low, ON>=P gives constant high
        bus_wr(8'd24, 32'd0);
        bus_wr(8'd25, 32'd5);
        bus_wr(8'd26, 32'd1);
        sample(2, 20, v);
        check("period_zero_ch2", v, 64'd0);
        bus_wr(8'd26, 32'd0);
        bus_wr(8'd24, 32'd10);
        bus_wr(8'd25, 32'd12);
        bus_wr(8'd26, 32'd1);
        sample(2, 20, v);
        check("on_ge_period_ch2", v, 64'h0000_0000_000F_FFFF);

        // Sync: ch0/ch1 synced at different phases, ch2 not synced
        bus_wr(8'd18, 32'd0);
        bus_wr(8'd17, 32'd3);
        bus_wr(8'd22, 32'd0);
        bus_wr(8'd20, 32'd10);
        bus_wr(8'd21, 32'd3);
        bus_wr(8'd26, 32'd0);
        bus_wr(8'd25, 32'd3);
        bus_wr(8'd18, 32'd9);
        bus_wr(8'd22, 32'd9);
        bus_wr(8'd26, 32'd1);
        repeat (3) @(negedge clk);
        sync_in = 1'b1;
        v0 = '0; v1 = '0; v2 = '0; e01 = '0; e2 = '0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 1) sync_in = 1'b0;
            if (k >= 2) begin
                v0  = {v0[62:0], pwm_out[0]};
                v1  = {v1[62:0], pwm_out[1]};
                v2  = {v2[62:0], pwm_out[2]};
                e01 = {e01[62:0], (((k - 2) % 10) < 3)};
                e2  = {e2[62:0], (((k + 2) % 10) < 3)};
            end
        end
        check("sync_ch0", v0, e01);
        check("sync_ch1", v1, e01);
        check("sync_unaffected_ch2", v2, e2);

        // Asynchronous reset mid-period
        @(negedge clk);
        check("pre_reset_pwm3", 64'(pwm_out[3]), 64'd1);
        #3 reset = 1'b0;
        #1 check("async_reset_pwm", 64'(pwm_out), 64'd0);
        check("async_reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus_rd(8'd16, 32'd0, "post_reset_period0", 1'b1);
        bus_rd(8'd30, 32'd0, "post_reset_cfg3", 1'b1);
        bus_rd(8'd21, 32'd0, "post_reset_on1", 1'b1);
        bus_rd(8'd31, 32'd0, "post_reset_status3", 1'b1);
        check("post_reset_pwm", 64'(pwm_out), 64'd0);

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
